// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
// Queues I2C commands in a small FIFO and hands them to the I2C core one at a
// time. Each command gets a single-cycle START with stable operands. The block
// then waits for the core to complete (or time out), returns one response, and
// enforces an idle gap before the next START.
module i2c_cmd_sequencer #(
  parameter int Data_width     = 8,
  parameter int Address        = 7,
  parameter int Depth          = 4,
  parameter int Gap_cycles     = 20,
  parameter int Timeout_cycles = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [Address-1:0]    cmd_addr,
  input  logic                  cmd_rd_wr,
  input  logic [Data_width-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Data_width-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  START,
  output logic [Address-1:0]    Slave_Address,
  output logic                  RD_WR,
  output logic [Data_width-1:0] Master_data_in,
  input  logic [Data_width-1:0] Master_dataout,
  input  logic                  Master_done
);

  localparam int AW = $clog2(Depth);
  localparam int EW = Address + 1 + Data_width;
  localparam int TW = (Timeout_cycles > 2) ? $clog2(Timeout_cycles) : 1;
  localparam int GW = (Gap_cycles > 0) ? $clog2(Gap_cycles + 1) : 1;
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(Timeout_cycles - 2);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(Gap_cycles);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, GAP} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   fifo_mem [Depth];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [EW-1:0]   head;
  logic            empty, full, push, pop;
  logic            done_q, done_evt, timeout_hit;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready   = ~full;
  assign push        = cmd_valid & ~full;
  assign head        = fifo_mem[rd_ptr[AW-1:0]];
  // Only a rising edge counts as completion, since the core holds done as a level.
  assign done_evt    = Master_done & ~done_q;
  // The timer has counted through the ISSUE cycle, so it trips one value early.
  assign timeout_hit = (timer == TMR_LAST);
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE) | ~empty;

  // Write each accepted command into the FIFO storage at the tail.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd_addr, cmd_rd_wr, cmd_wdata};
  end

  // Advance the FIFO pointers on push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode, with the FIFO pop and the START pulse.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    START     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        START     = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (done_evt || timeout_hit) state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = GAP;
      GAP:       if (gap_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Hold the core operands. They are loaded only when a command is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Slave_Address  <= '0;
      RD_WR          <= 1'b0;
      Master_data_in <= '0;
    end else if (pop) begin
      {Slave_Address, RD_WR, Master_data_in} <= head;
    end
  end

  // Drive the done edge detector, the timeout timer, and the gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q  <= 1'b0;
      timer   <= '0;
      gap_cnt <= '0;
    end else begin
      done_q <= Master_done;
      if (state == ISSUE)          timer   <= '0;
      else if (state == WAIT_DONE) timer   <= timer + TMR_ONE;
      if (state == RESP && rsp_ready) gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_ONE;
    end
  end

  // Capture the response when waiting ends. Completion takes priority over timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (state == WAIT_DONE) begin
      if (done_evt) begin
        rsp_data <= RD_WR ? Master_dataout : '0;
        rsp_err  <= 1'b0;
      end else if (timeout_hit) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer
// Scoreboard bench for i2c_cmd_sequencer. The stimulus pushes the expected
// START operands, the core behaviour and the expected responses into queues.
// Separate monitors compare against them when the DUT presents START or a response.
module tb_i2c_cmd_sequencer;

  localparam int DW  = 8;
  localparam int AW  = 7;
  localparam int GAP = 20;
  localparam int TMO = 512;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic [DW-1:0] wd;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  // beh: 0 = raise done after dly cycles, 1 = never finish (timeout), 2 = abandoned by reset
  typedef struct {
    int            beh;
    int            dly;
    logic [DW-1:0] data;
  } core_t;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_rd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, busy, START, RD_WR, Master_done;
  logic [DW-1:0] rsp_data, Master_data_in, Master_dataout;
  logic [AW-1:0] Slave_Address;

  cmd_t  exp_cmd_q[$];
  rsp_t  exp_rsp_q[$];
  core_t core_q[$];
  cmd_t  last_cmd, sc;
  rsp_t  er;
  core_t cb;

  int checks = 0, failures = 0;
  int cyc = 0, rsp_count = 0, start_count = 0;
  int hs_cyc = 0, core_start_cyc = 0, n_core = 0;
  bit hs_pending = 0, gap_exact = 0;

  i2c_cmd_sequencer #(
    .Data_width(DW), .Address(AW), .Depth(4), .Gap_cycles(GAP), .Timeout_cycles(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rd_wr(cmd_rd_wr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .START(START), .Slave_Address(Slave_Address), .RD_WR(RD_WR),
    .Master_data_in(Master_data_in), .Master_dataout(Master_dataout), .Master_done(Master_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Queue what the core model should do and, unless the command is abandoned, the expected response.
  task automatic expect_txn(input int beh, input int dly, input logic [DW-1:0] cdata,
                            input logic [DW-1:0] edata, input logic eerr);
    core_t c;
    rsp_t  r;
    c.beh = beh; c.dly = dly; c.data = cdata;
    core_q.push_back(c);
    if (beh != 2) begin
      r.data = edata; r.err = eerr;
      exp_rsp_q.push_back(r);
    end
  endtask

  // Offer one command for a single cycle and check whether it is accepted.
  task automatic apply_stimulus(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd,
                                input logic exp_acc);
    cmd_t c;
    cmd_valid = 1'b1; cmd_addr = a; cmd_rd_wr = rd; cmd_wdata = wd;
    @(negedge clk);
    check_output("cmd_ready", cmd_ready, exp_acc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (exp_acc) begin
      c.addr = a; c.rd = rd; c.wd = wd;
      exp_cmd_q.push_back(c);
    end
  endtask

  task automatic wait_rsp(input int target, input int bound);
    int n = 0;
    while (rsp_count < target && n < bound) begin @(posedge clk); #1; n++; end
    check_output("rsp_count", rsp_count, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_start"}, START, 0);
    check_output({tag, "_operands"}, {Slave_Address, RD_WR, Master_data_in}, 0);
    check_output({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_data}, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  // START monitor: check the operands against the next queued command and the gap since the last response.
  always @(negedge clk) begin
    if (rst && START) begin
      start_count++;
      if (exp_cmd_q.size() == 0) begin
        check_output("unexpected_start", 1, 0);
      end else begin
        sc = exp_cmd_q.pop_front();
        check_output("start_operands", {Slave_Address, RD_WR, Master_data_in}, {sc.addr, sc.rd, sc.wd});
        last_cmd = sc;
      end
      if (hs_pending) begin
        if (gap_exact) check_output("gap_exact", cyc - hs_cyc, GAP + 3);
        else           check_output("gap_min", (cyc - hs_cyc) >= GAP + 3, 1);
        hs_pending = 0;
      end
    end
  end

  // Response monitor: pop the expected payload on each accepted response.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        check_output("unexpected_rsp", 1, 0);
      end else begin
        er = exp_rsp_q.pop_front();
        check_output("rsp_data", rsp_data, er.data);
        check_output("rsp_err", rsp_err, er.err);
        check_output("operands_held", {Slave_Address, RD_WR, Master_data_in},
                     {last_cmd.addr, last_cmd.rd, last_cmd.wd});
      end
      rsp_count++;
      hs_cyc = cyc;
      hs_pending = 1;
    end
  end

  // Core model: keep an old done level high across START, then complete, stay silent, or be abandoned.
  initial begin : core_model
    Master_done = 1'b0;
    Master_dataout = '0;
    forever begin
      @(negedge clk);
      if (rst && START) begin
        core_start_cyc = cyc;
        if (core_q.size() == 0) begin
          check_output("core_unexpected_start", 1, 0);
        end else begin
          cb = core_q.pop_front();
          repeat (4) begin @(posedge clk); #1; end
          Master_done = 1'b0;
          if (cb.beh == 0) begin
            repeat (cb.dly) begin @(posedge clk); #1; end
            Master_dataout = cb.data;
            Master_done = 1'b1;
            @(negedge clk);
            check_output("done_to_rsp_early", rsp_valid, 0);
            @(negedge clk);
            check_output("done_to_rsp", rsp_valid, 1);
          end else if (cb.beh == 1) begin
            n_core = 0;
            while (rsp_valid !== 1'b1 && n_core < TMO + 20) begin @(negedge clk); n_core++; end
            check_output("timeout_latency", cyc - core_start_cyc, TMO);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n, sc0;
    bit hold_ok;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rd_wr = 1'b0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    wait_cycles(2);

    // Write: rsp_data must be zero even though the core drives a read byte.
    $display("[TB] write test");
    expect_txn(0, 296, 8'hEE, 8'h00, 1'b0);
    apply_stimulus(7'h55, 1'b0, 8'h5A, 1'b1);
    @(negedge clk);
    check_output("push_to_start_n1", START, 0);
    @(negedge clk);
    check_output("push_to_start_n2", START, 1);
    @(posedge clk); #1;
    wait_rsp(1, 600);

    // Two reads back to back. Done is still high from the write and must not complete them early.
    $display("[TB] read test");
    expect_txn(0, 40, 8'hA5, 8'hA5, 1'b0);
    apply_stimulus(7'h55, 1'b1, 8'h00, 1'b1);
    expect_txn(0, 10, 8'h5B, 8'h5B, 1'b0);
    apply_stimulus(7'h21, 1'b1, 8'h77, 1'b1);
    wait_rsp(3, 400);

    // Backpressure: hold a read of 0x3C while filling the FIFO; the fifth push is refused.
    $display("[TB] backpressure and queue-full test");
    rsp_ready = 1'b0;
    expect_txn(0, 20, 8'h3C, 8'h3C, 1'b0);
    apply_stimulus(7'h10, 1'b1, 8'h00, 1'b1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin wait_cycles(1); n++; end
    check_output("bp_rsp_valid", rsp_valid, 1);
    expect_txn(0, 15, 8'hFF, 8'h00, 1'b0);
    apply_stimulus(7'h11, 1'b0, 8'h01, 1'b1);
    expect_txn(0, 15, 8'h99, 8'h99, 1'b0);
    apply_stimulus(7'h12, 1'b1, 8'h00, 1'b1);
    expect_txn(0, 15, 8'hFF, 8'h00, 1'b0);
    apply_stimulus(7'h13, 1'b0, 8'h03, 1'b1);
    expect_txn(0, 15, 8'h42, 8'h42, 1'b0);
    apply_stimulus(7'h14, 1'b1, 8'h00, 1'b1);
    apply_stimulus(7'h15, 1'b0, 8'h05, 1'b0);
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_data === 8'h3C && rsp_err === 1'b0 && START === 1'b0 && busy === 1'b1))
        hold_ok = 1'b0;
    end
    check_output("bp_hold", hold_ok, 1);
    @(posedge clk); #1;
    gap_exact = 1;
    rsp_ready = 1'b1;
    wait_rsp(8, 800);
    gap_exact = 0;

    // Timeout: the core never finishes. The next command must then complete normally.
    $display("[TB] timeout test");
    expect_txn(1, 0, 8'h00, 8'h00, 1'b1);
    apply_stimulus(7'h2A, 1'b1, 8'h00, 1'b1);
    wait_rsp(9, TMO + 100);
    expect_txn(0, 12, 8'hC3, 8'hC3, 1'b0);
    apply_stimulus(7'h2B, 1'b1, 8'h00, 1'b1);
    wait_rsp(10, 200);
    check_output("queues_drained", exp_rsp_q.size() + exp_cmd_q.size() + core_q.size(), 0);

    // Reset mid-WAIT_DONE with two commands queued.
    $display("[TB] reset test");
    sc0 = start_count;
    expect_txn(2, 0, 8'h00, 8'h00, 1'b0);
    apply_stimulus(7'h30, 1'b0, 8'h30, 1'b1);
    n = 0;
    while (start_count == sc0 && n < 100) begin wait_cycles(1); n++; end
    check_output("reset_test_started", start_count, sc0 + 1);
    wait_cycles(10);
    expect_txn(2, 0, 8'h00, 8'h00, 1'b0);
    apply_stimulus(7'h31, 1'b1, 8'h00, 1'b1);
    expect_txn(2, 0, 8'h00, 8'h00, 1'b0);
    apply_stimulus(7'h32, 1'b0, 8'h32, 1'b1);
    check_output("busy_before_reset", busy, 1);
    rst = 1'b0;
    exp_cmd_q.delete(); exp_rsp_q.delete(); core_q.delete();
    hs_pending = 0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    wait_cycles(3);
    rst = 1'b1;
    sc0 = start_count;
    wait_cycles(100);
    check_output("no_start_after_reset", start_count, sc0);
    check_output("idle_after_reset", {busy, cmd_ready, rsp_valid}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
